// File: rtl/adder_rr_arbiter_if.sv
// Requester/consumer bundle for adder_rr_arbiter: operands, grant pulse and result handshake.
// slave = arbiter side, master = requesters plus result consumer.
interface adder_rr_arbiter_if #(
    parameter int N = 8
) ();
    logic [3:0]     req;
    logic [4*N-1:0] num1_i;
    logic [4*N-1:0] num2_i;
    logic [3:0]     gnt;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_id;
    logic [N:0]     result;
    logic           busy;

    modport slave (
        input  req, num1_i, num2_i, out_ready,
        output gnt, out_valid, out_id, result, busy
    );

    modport master (
        output req, num1_i, num2_i, out_ready,
        input  gnt, out_valid, out_id, result, busy
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among 4 requesters; op_count under ADDER_ARB_CNT_EN.
// Latency: gnt 1 cycle after req sampled in IDLE, out_valid 1 cycle later.
// Backpressure: result held in HOLD until out_ready; req ignored outside IDLE.
module RippleCarry_Adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[N];
endmodule

module adder_rr_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    adder_rr_arbiter_if.slave   bus
`ifdef ADDER_ARB_CNT_EN
    ,
    output logic [15:0]         op_count
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [N-1:0]    op_a_q, op_a_d;
    logic [N-1:0]    op_b_q, op_b_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            out_valid_q, out_valid_d;
    logic [1:0]      out_id_q, out_id_d;
    logic [N:0]      result_q, result_d;

    logic [N-1:0]    sum;
    logic            cout;
    logic            sel_vld;
    logic [1:0]      sel_idx;
    logic [1:0]      cand;

    RippleCarry_Adder #(.N(N)) u_adder (
        .a    (op_a_q),
        .b    (op_b_q),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Scan downward so the candidate closest to ptr is the one left standing.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = ptr_q;
        cand    = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (bus.req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        gnt_d       = '0;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        result_d    = result_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    op_a_d         = bus.num1_i[int'(sel_idx)*N +: N];
                    op_b_d         = bus.num2_i[int'(sel_idx)*N +: N];
                    out_id_d       = sel_idx;
                    gnt_d[sel_idx] = 1'b1;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                result_d    = {cout, sum};
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    ptr_d       = out_id_q + 2'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            result_q    <= result_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.result    = result_q;
    assign bus.busy      = (state_q != IDLE);

`ifdef ADDER_ARB_CNT_EN
    logic [15:0] op_count_q, op_count_d;

    // Counts accepted results; natural 16-bit wrap.
    always_comb begin
        op_count_d = op_count_q;
        if (state_q == HOLD && bus.out_ready) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: expected grants/results queued by stimulus, popped by a monitor.
module tb_adder_rr_arbiter;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adder_rr_arbiter_if #(.N(N)) bif ();

`ifdef ADDER_ARB_CNT_EN
    logic [15:0] op_count;
`endif

    adder_rr_arbiter #(.N(N), .NREQ(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif.slave)
`ifdef ADDER_ARB_CNT_EN
        ,
        .op_count (op_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         exp_gnt_q[$];
    int         exp_id_q[$];
    logic [N:0] exp_res_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every grant pulse and every newly presented result is popped and compared.
    initial begin
        logic vld_seen;
        int   e;
        vld_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.gnt != 4'b0000) begin
                if (exp_gnt_q.size() == 0) begin
                    check("unexpected_gnt", 32'(bif.gnt), 32'h0);
                end else begin
                    e = exp_gnt_q.pop_front();
                    check("sb_gnt", 32'(bif.gnt), 32'(4'b0001 << e));
                end
            end
            if (bif.out_valid && !vld_seen) begin
                if (exp_id_q.size() == 0) begin
                    check("unexpected_valid", 32'(bif.out_valid), 32'h0);
                end else begin
                    check("sb_out_id", 32'(bif.out_id), 32'(exp_id_q.pop_front()));
                    check("sb_result", 32'(bif.result), 32'(exp_res_q.pop_front()));
                end
            end
            vld_seen = bif.out_valid;
        end
    end

    task automatic expect_txn(input int idx, input logic [N:0] res, input bit with_result);
        exp_gnt_q.push_back(idx);
        if (with_result) begin
            exp_id_q.push_back(idx);
            exp_res_q.push_back(res);
        end
    endtask

    task automatic set_ops(input int idx, input logic [N-1:0] a, input logic [N-1:0] b);
        bif.num1_i[idx*N +: N] = a;
        bif.num2_i[idx*N +: N] = b;
    endtask

    // Returns the number of falling edges until a grant shows up.
    task automatic wait_gnt(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bif.gnt == 4'b0000 && cyc < 30);
        if (cyc >= 30) check("gnt_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (bif.busy && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 30) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic single(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N:0] res);
        int cyc;
        set_ops(idx, a, b);
        expect_txn(idx, res, 1'b1);
        bif.req = 4'(1 << idx);
        wait_gnt(cyc);
        bif.req = 4'b0000;
        @(negedge clk);
        wait_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int cyc;
        bif.req       = 4'b0000;
        bif.num1_i    = '0;
        bif.num2_i    = '0;
        bif.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt",       32'(bif.gnt),       32'h0);
        check("rst_out_valid", 32'(bif.out_valid), 32'h0);
        check("rst_out_id",    32'(bif.out_id),    32'h0);
        check("rst_result",    32'(bif.result),    32'h0);
        check("rst_busy",      32'(bif.busy),      32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req_busy", 32'(bif.busy), 32'h0);

        // Single request with latency checks
        set_ops(0, 8'h0F, 8'h01);
        expect_txn(0, 9'h010, 1'b1);
        bif.req = 4'b0001;
        wait_gnt(cyc);
        check("t1_gnt_latency", 32'(cyc), 32'd1);
        check("t1_gnt",         32'(bif.gnt), 32'h1);
        check("t1_busy",        32'(bif.busy), 32'h1);
        bif.req = 4'b0000;
        @(negedge clk);
        check("t1_valid",  32'(bif.out_valid), 32'h1);
        check("t1_result", 32'(bif.result),    32'h010);
        check("t1_gnt_pulse", 32'(bif.gnt),    32'h0);
        @(negedge clk);
        check("t1_valid_clr", 32'(bif.out_valid), 32'h0);
        check("t1_idle",      32'(bif.busy),      32'h0);

        // Carry out
        single(2, 8'hFF, 8'hFF, 9'h1FE);
        check("carry_result", 32'(bif.result), 32'h1FE);
        check("carry_id",     32'(bif.out_id), 32'h2);

        // Round robin from ptr 0 with all requests held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bif.num1_i = 32'h80_C0_7F_10;
        bif.num2_i = 32'h80_50_01_22;
        expect_txn(0, 9'h032, 1'b1);
        expect_txn(1, 9'h080, 1'b1);
        expect_txn(2, 9'h110, 1'b1);
        expect_txn(3, 9'h100, 1'b1);
        expect_txn(0, 9'h032, 1'b1);
        bif.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(cyc);
            if (g > 0) check("rr_gnt_spacing", 32'(cyc), 32'd3);
        end
        bif.req = 4'b0000;
        @(negedge clk);
        wait_idle();

        // Backpressure; requester 3 raises req while the result is held
        bif.out_ready = 1'b0;
        set_ops(1, 8'h33, 8'h44);
        set_ops(3, 8'h01, 8'hFE);
        expect_txn(1, 9'h077, 1'b1);
        bif.req = 4'b0010;
        wait_gnt(cyc);
        check("bp_gnt", 32'(bif.gnt), 32'h2);
        bif.req = 4'b1000;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",  32'(bif.out_valid), 32'h1);
            check("bp_result", 32'(bif.result),    32'h077);
            check("bp_id",     32'(bif.out_id),    32'h1);
            check("bp_busy",   32'(bif.busy),      32'h1);
            check("bp_no_gnt", 32'(bif.gnt),       32'h0);
            @(negedge clk);
        end
        expect_txn(3, 9'h0FF, 1'b1);
        bif.out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_clr", 32'(bif.out_valid), 32'h0);
        check("bp_idle",      32'(bif.busy),      32'h0);
        wait_gnt(cyc);
        check("bp_next_gnt", 32'(bif.gnt), 32'h8);
        bif.req = 4'b0000;
        @(negedge clk);
        wait_idle();

        // Move ptr away from 0, then reset during EXEC
        single(2, 8'h12, 8'h34, 9'h046);
        set_ops(0, 8'h55, 8'h66);
        expect_txn(0, '0, 1'b0);
        bif.req = 4'b0001;
        wait_gnt(cyc);
        bif.req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_gnt",    32'(bif.gnt),       32'h0);
        check("mid_rst_valid",  32'(bif.out_valid), 32'h0);
        check("mid_rst_id",     32'(bif.out_id),    32'h0);
        check("mid_rst_result", 32'(bif.result),    32'h0);
        check("mid_rst_busy",   32'(bif.busy),      32'h0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_valid", 32'(bif.out_valid), 32'h0);
        end
        set_ops(1, 8'hAA, 8'h55);
        set_ops(3, 8'h7F, 8'h7F);
        expect_txn(1, 9'h0FF, 1'b1);
        expect_txn(3, 9'h0FE, 1'b1);
        bif.req = 4'b1010;
        wait_gnt(cyc);
        check("post_rst_first_gnt", 32'(bif.gnt), 32'h2);
        bif.req = 4'b1000;
        wait_gnt(cyc);
        bif.req = 4'b0000;
        @(negedge clk);
        wait_idle();
        single(0, 8'h01, 8'h01, 9'h002);

`ifdef ADDER_ARB_CNT_EN
        check("op_count", 32'(op_count), 32'd3);
`endif

        repeat (3) @(negedge clk);
        check("sb_gnt_drained", 32'(exp_gnt_q.size()), 32'd0);
        check("sb_res_drained", 32'(exp_id_q.size()),  32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
